// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: shared state encoding, result-flag bit positions and width defaults for alu_arb.
package alu_arb_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int SEL_W_DEF  = 4;
    localparam int FLAG_W     = 5;
    localparam int FLAG_C     = 4;
    localparam int FLAG_Z     = 3;
    localparam int FLAG_N     = 2;
    localparam int FLAG_V     = 1;
    localparam int FLAG_U     = 0;
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
endpackage

// File: rtl/ALU_32bit.sv
// ALU_32bit: combinational 32-bit ALU; overflow/underflow split signed add/sub wrap by operand-A sign.
module ALU_32bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  sel,
    output logic [31:0] result,
    output logic        carry,
    output logic        zero,
    output logic        negative,
    output logic        overflow,
    output logic        underflow
);
    logic [32:0] sum;
    logic [32:0] diff;
    logic        sv;
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};
    always_comb begin
        result = a;
        case (sel)
            4'd0: result = sum[31:0];
            4'd1: result = diff[31:0];
            4'd2: result = a & b;
            4'd3: result = a | b;
            4'd4: result = a ^ b;
            4'd5: result = ~(a | b);
            4'd6: result = a << b[4:0];
            4'd7: result = a >> b[4:0];
            4'd8: result = $signed(a) >>> b[4:0];
            default: result = a;
        endcase
    end
    assign sv        = sel == 4'd0 ? (a[31] == b[31] && sum[31] != a[31]) :
                       sel == 4'd1 ? (a[31] != b[31] && diff[31] != a[31]) : 1'b0;
    assign carry     = sel == 4'd0 ? sum[32] : sel == 4'd1 ? diff[32] : 1'b0;
    assign overflow  = sv && !a[31];
    assign underflow = sv && a[31];
    assign zero      = result == 32'd0;
    assign negative  = result[31];
endmodule

// File: rtl/alu_arb_grant.sv
// alu_arb_grant: one-hot two-way grant; round-robin on last_grant with ALU_ARB_RR_EN, else requester 0 wins.
module alu_arb_grant (
    input  logic [1:0] valid,
`ifdef ALU_ARB_RR_EN
    input  logic       last_grant,
`endif
    output logic [1:0] grant
);
`ifdef ALU_ARB_RR_EN
    assign grant[0] = valid[0] && (!valid[1] || last_grant);
    assign grant[1] = valid[1] && (!valid[0] || !last_grant);
`else
    assign grant[0] = valid[0];
    assign grant[1] = valid[1] && !valid[0];
`endif
endmodule

// File: rtl/alu_arb.sv
// alu_arb: two requesters share one ALU_32bit through an IDLE/EXEC/RESP handshake FSM.
// Define ALU_ARB_RR_EN for round-robin arbitration; fixed priority (requester 0) otherwise.
module alu_arb
    import alu_arb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int SEL_W  = SEL_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [SEL_W-1:0]  req0_sel,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [SEL_W-1:0]  req1_sel,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_data,
    output logic [FLAG_W-1:0] rsp_flags,
    output logic              busy
);
    state_t              state, state_nxt;
    logic [1:0]          grant;
    logic                accept;
    logic [DATA_W-1:0]   op_a, op_b, alu_y;
    logic [SEL_W-1:0]    op_sel;
    logic                op_id;
    logic [FLAG_W-1:0]   alu_flags;
`ifdef ALU_ARB_RR_EN
    logic                last_grant;
`endif

    alu_arb_grant u_grant (
        .valid      ({req1_valid, req0_valid}),
`ifdef ALU_ARB_RR_EN
        .last_grant (last_grant),
`endif
        .grant      (grant)
    );

    ALU_32bit u_alu (
        .a         (op_a),
        .b         (op_b),
        .sel       (op_sel),
        .result    (alu_y),
        .carry     (alu_flags[FLAG_C]),
        .zero      (alu_flags[FLAG_Z]),
        .negative  (alu_flags[FLAG_N]),
        .overflow  (alu_flags[FLAG_V]),
        .underflow (alu_flags[FLAG_U])
    );

    assign req0_ready = state == IDLE && grant[0];
    assign req1_ready = state == IDLE && grant[1];
    assign accept     = req0_ready || req1_ready;
    assign rsp_valid  = state == RESP;
    assign busy       = state != IDLE;

    always_comb begin
        state_nxt = state == IDLE ? (accept ? EXEC : IDLE) :
                    state == EXEC ? RESP :
                    (rsp_ready ? IDLE : RESP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            op_a   <= '0;
            op_b   <= '0;
            op_sel <= '0;
            op_id  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_a   <= req1_ready ? req1_a : req0_a;
                op_b   <= req1_ready ? req1_b : req0_b;
                op_sel <= req1_ready ? req1_sel : req0_sel;
                op_id  <= req1_ready;
            end
        end
    end

    // Result registers load only at the edge leaving EXEC and hold through RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_id    <= 1'b0;
            rsp_data  <= '0;
            rsp_flags <= '0;
        end else if (state == EXEC) begin
            rsp_id    <= op_id;
            rsp_data  <= alu_y;
            rsp_flags <= alu_flags;
        end
    end

`ifdef ALU_ARB_RR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) last_grant <= 1'b1;
        else if (accept) last_grant <= req1_ready;
    end
`endif
endmodule

// File: tb/tb_alu_arb.sv
// tb_alu_arb: directed self-checking bench for alu_arb.
module tb_alu_arb;
    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_sel, req1_sel;
    logic        rsp_valid, rsp_ready, rsp_id, busy;
    logic [31:0] rsp_data;
    logic [4:0]  rsp_flags;
    int          n_cmp = 0;
    int          n_err = 0;

    alu_arb dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_sel   (req0_sel),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_sel   (req1_sel),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_flags  (rsp_flags),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input bit who, input logic [31:0] a, input logic [31:0] b, input logic [3:0] sel);
        if (who) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_sel = sel;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_sel = sel;
        end
    endtask

    // Single-requester operation with rsp_ready high: ready now, EXEC after 1 edge, RESP after 2, IDLE after 3.
    task automatic run_op(input string tag, input bit who, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] sel, input logic [31:0] exp_d, input logic [4:0] exp_f);
        set_req(who, a, b, sel);
        #1;
        chk({tag, ".ready"}, {req1_ready, req0_ready}, who ? 2'b10 : 2'b01);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;
        chk({tag, ".exec_valid"}, rsp_valid, 1'b0);
        chk({tag, ".exec_busy"}, busy, 1'b1);
        tick();
        chk({tag, ".rsp_valid"}, rsp_valid, 1'b1);
        chk({tag, ".rsp_id"}, rsp_id, who);
        chk({tag, ".rsp_data"}, rsp_data, exp_d);
        chk({tag, ".rsp_flags"}, rsp_flags, exp_f);
        tick();
        chk({tag, ".idle_busy"}, busy, 1'b0);
    endtask

    initial begin
        logic [3:0] exp_ids;
        bit g;
        rst = 1'b1;
        rsp_ready = 1'b1;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_sel = '0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_sel = '0;
        #2;
        chk("reset.rsp_valid", rsp_valid, 1'b0);
        chk("reset.busy", busy, 1'b0);
        chk("reset.rsp_id", rsp_id, 1'b0);
        chk("reset.rsp_data", rsp_data, 32'd0);
        chk("reset.rsp_flags", rsp_flags, 5'd0);
        chk("reset.ready", {req1_ready, req0_ready}, 2'b00);
        tick();
        tick();
        rst = 1'b0;

        run_op("add0", 1'b0, 32'h0A0A0A0A, 32'h02020202, 4'd0, 32'h0C0C0C0C, 5'b00000);
        run_op("sub1", 1'b1, 32'h0A0A0A0A, 32'h0A0A0A0A, 4'd1, 32'h00000000, 5'b01000);
        run_op("addov", 1'b0, 32'h7FFFFFFF, 32'h00000001, 4'd0, 32'h80000000, 5'b00110);
        run_op("subbrw", 1'b1, 32'h00000000, 32'h00000001, 4'd1, 32'hFFFFFFFF, 5'b10100);
        run_op("and", 1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 4'd2, 32'hF000F000, 5'b00100);
        run_op("pass15", 1'b1, 32'h12345678, 32'h0000FFFF, 4'd15, 32'h12345678, 5'b00000);

`ifdef ALU_ARB_RR_EN
        exp_ids = 4'b1010;
`else
        exp_ids = 4'b0000;
`endif
        set_req(1'b0, 32'h10, 32'h20, 4'd0);
        set_req(1'b1, 32'h30, 32'h10, 4'd1);
        for (int k = 0; k < 4; k++) begin
            #1;
            for (int t = 0; t < 20 && !(req0_ready || req1_ready); t++) tick();
            chk($sformatf("both.op%0d.onehot", k), {req1_ready, req0_ready}, exp_ids[k] ? 2'b10 : 2'b01);
            g = req1_ready;
            chk($sformatf("both.op%0d.grant", k), g, exp_ids[k]);
            tick();
            tick();
            chk($sformatf("both.op%0d.rsp_valid", k), rsp_valid, 1'b1);
            chk($sformatf("both.op%0d.rsp_id", k), rsp_id, exp_ids[k]);
            chk($sformatf("both.op%0d.rsp_data", k), rsp_data, exp_ids[k] ? 32'h20 : 32'h30);
            tick();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        rsp_ready = 1'b0;
        set_req(1'b0, 32'hFFFF0000, 32'h0F0F0F0F, 4'd4);
        set_req(1'b1, 32'h5, 32'h3, 4'd1);
        #1;
        chk("stall.grant", {req1_ready, req0_ready}, 2'b01);
        tick();
        tick();
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("stall.c%0d.valid", i), rsp_valid, 1'b1);
            chk($sformatf("stall.c%0d.data", i), rsp_data, 32'hF0F00F0F);
            chk($sformatf("stall.c%0d.id", i), rsp_id, 1'b0);
            chk($sformatf("stall.c%0d.flags", i), rsp_flags, 5'b00100);
            chk($sformatf("stall.c%0d.ready", i), {req1_ready, req0_ready}, 2'b00);
            chk($sformatf("stall.c%0d.busy", i), busy, 1'b1);
            tick();
        end
        rsp_ready = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
        chk("stall.release_busy", busy, 1'b0);
        chk("stall.release_valid", rsp_valid, 1'b0);

        set_req(1'b0, 32'd1, 32'd2, 4'd0);
        #1;
        chk("rst.accept", req0_ready, 1'b1);
        tick();
        req0_valid = 1'b0;
        #1;
        chk("rst.in_exec", busy, 1'b1);
        rst = 1'b1;
        #1;
        chk("rst.async_valid", rsp_valid, 1'b0);
        chk("rst.async_busy", busy, 1'b0);
        chk("rst.async_data", rsp_data, 32'd0);
        chk("rst.async_flags", rsp_flags, 5'd0);
        chk("rst.async_id", rsp_id, 1'b0);
        tick();
        rst = 1'b0;
        tick();
        chk("rst.no_rsp_valid", rsp_valid, 1'b0);
        chk("rst.no_rsp_busy", busy, 1'b0);
        set_req(1'b0, 32'h40, 32'h2, 4'd6);
        set_req(1'b1, 32'h9, 32'h9, 4'd0);
        #1;
        chk("post_rst.grant", {req1_ready, req0_ready}, 2'b01);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
        chk("post_rst.rsp_valid", rsp_valid, 1'b1);
        chk("post_rst.rsp_id", rsp_id, 1'b0);
        chk("post_rst.rsp_data", rsp_data, 32'h100);
        chk("post_rst.rsp_flags", rsp_flags, 5'b00000);
        tick();
        chk("post_rst.idle", busy, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
